// File: rtl/sisc_dmem_resp.sv
// Wait-state data memory for the SISC mem stage: one request at a time, fixed
// WAIT-cycle latency, single-cycle registered ack with load data and range error.
module sisc_dmem_resp #(
  parameter int DW    = 32,
  parameter int AW    = 8,
  parameter int DEPTH = 16,
  parameter int WAIT  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_ack,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_err,
  output logic          busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAITING, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [DW-1:0] mem [DEPTH];

  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          in_range;
  logic          enter_resp;

  // With WAIT=0 the access completes on the request edge itself, before the
  // capture registers hold anything, so the live inputs are used in IDLE.
  always_comb begin
    acc_we     = cap_we;
    acc_addr   = cap_addr;
    acc_wdata  = cap_wdata;
    enter_resp = 1'b0;
    if (state == IDLE) begin
      acc_we     = mem_we;
      acc_addr   = mem_addr;
      acc_wdata  = mem_wdata;
      enter_resp = mem_req && (WAIT == 0);
    end else if (state == WAITING) begin
      enter_resp = (cnt == 4'd1);
    end
    in_range = (32'(acc_addr) < 32'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      if (enter_resp) begin
        mem_ack <= 1'b1;
        mem_err <= !in_range;
        if (in_range) begin
          if (acc_we) mem[acc_addr[IW-1:0]] <= acc_wdata;
          else        mem_rdata <= mem[acc_addr[IW-1:0]];
        end else if (!acc_we) begin
          mem_rdata <= '0;
        end
      end
      case (state)
        IDLE: begin
          if (mem_req) begin
            cap_we    <= mem_we;
            cap_addr  <= mem_addr;
            cap_wdata <= mem_wdata;
            cnt       <= 4'(WAIT);
            state     <= (WAIT == 0) ? RESP : WAITING;
          end
        end
        WAITING: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
